// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 Avalon-MM host.
// Contents: the slave register map, the start command, the status done bit,
// the host FSM state type and a helper that extracts one 32-bit word from a
// 512-bit message block.
package sha1_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ADDR_CTRL       = 32'd0;
  localparam word_t ADDR_MSG_FIRST  = 32'd1;
  localparam word_t ADDR_MSG_LAST   = 32'd16;
  localparam word_t ADDR_DIG_FIRST  = 32'd17;
  localparam word_t ADDR_DIG_LAST   = 32'd21;
  localparam word_t CTRL_START      = 32'h1;
  localparam int    STATUS_DONE_BIT = 1;
  localparam int    MSG_WORDS       = 16;
  localparam int    DIG_WORDS       = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MSG,
    ST_WR_START,
    ST_POLL,
    ST_POLL_CHK,
    ST_GAP,
    ST_RD_DIG,
    ST_DONE,
    ST_ABORT
  } host_state_t;

  // Word 0 is the most significant word (bits 511:480), which goes to address 1.
  function automatic word_t blk_word(input logic [511:0] blk, input int idx);
    return blk[511 - 32*idx -: 32];
  endfunction

endpackage

// File: rtl/sha1_host_rd_pipe.sv
// Digest read pipeline for the SHA-1 host.
// On start it issues five back-to-back reads at addresses 17..21 and captures
// readdata one cycle after each issue (slave read latency is fixed at 1).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          one-cycle request to begin the five-word read burst
//   readdata       slave read data (valid the cycle after an issued read)
//   read, address  registered read strobe and word address for this burst
//   last_capture   high in the cycle in which the H4 word is being captured
//   digest         {H0,H1,H2,H3,H4}, held between bursts
module sha1_host_rd_pipe
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  readdata,
  output logic         read,
  output logic [31:0]  address,
  output logic         last_capture,
  output logic [159:0] digest
);

  logic [2:0] issue_idx;
  logic [2:0] cap_idx;
  logic       cap_valid;
  word_t      dig_w [DIG_WORDS];

  // Issue side: the capture stage is the issue stage delayed by one cycle,
  // which lines each captured word up with the address that requested it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read      <= 1'b0;
      address   <= '0;
      issue_idx <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
    end else begin
      cap_valid <= read;
      cap_idx   <= issue_idx;
      if (start) begin
        read      <= 1'b1;
        address   <= ADDR_DIG_FIRST;
        issue_idx <= '0;
      end else if (read) begin
        if (address == ADDR_DIG_LAST) begin
          read    <= 1'b0;
          address <= '0;
        end else begin
          address   <= address + 32'd1;
          issue_idx <= issue_idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIG_WORDS; i++) dig_w[i] <= '0;
    end else if (cap_valid) begin
      dig_w[cap_idx] <= readdata;
    end
  end

  assign last_capture = cap_valid && (cap_idx == 3'(DIG_WORDS - 1));
  assign digest       = {dig_w[0], dig_w[1], dig_w[2], dig_w[3], dig_w[4]};

endmodule

// File: rtl/sha1_avalon_host.sv
// Avalon-MM master that runs one SHA-1 block through the register slave:
// writes the 16 message words, writes the start command, polls status until
// done (or gives up), then reads the 160-bit digest.
// Handshake: a block transfers on a rising edge where blk_valid and blk_ready
//   are both high; blk_ready is high only in IDLE, and blk_data is latched at
//   that edge and ignored afterwards.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   blk_valid/blk_ready/blk_data  512-bit message block input
//   digest, digest_valid          result and its one-cycle pulse
//   timeout_err                   one-cycle pulse when polling gives up
//   busy                          high from accept through the final pulse
//   write/read/address/writedata  registered Avalon-MM master outputs
//   readdata                      slave read data, latency 1
//   state_dbg                     current FSM state (host_state_t encoding)
module sha1_avalon_host
  import sha1_pkg::*;
#(
  parameter int TIMEOUT_POLLS = 4096,
  parameter int POLL_GAP      = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         timeout_err,
  output logic         busy,
  output logic         write,
  output logic         read,
  output logic [31:0]  address,
  output logic [31:0]  writedata,
  input  logic [31:0]  readdata,
  output logic [3:0]   state_dbg
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_POLLS);
  localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  host_state_t state, state_d;
  logic [3:0]  msg_idx, msg_idx_d;
  logic [15:0] poll_cnt, poll_cnt_d;
  logic [15:0] gap_cnt, gap_cnt_d;
  word_t       msg_buf [MSG_WORDS];

  logic        accept;
  logic        rd_start;
  logic        fsm_read, fsm_read_d;
  logic        write_d;
  word_t       fsm_addr, fsm_addr_d;
  word_t       writedata_d;

  logic        pipe_read;
  logic [31:0] pipe_addr;
  logic        pipe_last;

  assign accept   = (state == ST_IDLE) && blk_valid;
  assign rd_start = (state == ST_POLL_CHK) && readdata[STATUS_DONE_BIT];

  // Next state, next counters, and the next values of the registered Avalon
  // outputs. Outputs are decoded from the next state so that they appear in
  // the same cycle the FSM enters the state that owns them.
  always_comb begin
    state_d     = state;
    msg_idx_d   = msg_idx;
    poll_cnt_d  = poll_cnt;
    gap_cnt_d   = gap_cnt;
    write_d     = 1'b0;
    fsm_read_d  = 1'b0;
    fsm_addr_d  = '0;
    writedata_d = '0;

    case (state)
      ST_IDLE: begin
        if (blk_valid) begin
          state_d    = ST_WR_MSG;
          msg_idx_d  = '0;
          poll_cnt_d = '0;
        end
      end
      ST_WR_MSG: begin
        if (msg_idx == 4'(MSG_WORDS - 1)) state_d = ST_WR_START;
        else msg_idx_d = msg_idx + 4'd1;
      end
      ST_WR_START: state_d = ST_POLL;
      ST_POLL: begin
        state_d    = ST_POLL_CHK;
        poll_cnt_d = poll_cnt + 16'd1;
      end
      ST_POLL_CHK: begin
        if (readdata[STATUS_DONE_BIT]) state_d = ST_RD_DIG;
        else if (poll_cnt == TO_LIMIT) state_d = ST_ABORT;
        else if (POLL_GAP == 0) state_d = ST_POLL;
        else begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = ST_POLL;
        else gap_cnt_d = gap_cnt + 16'd1;
      end
      ST_RD_DIG: if (pipe_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_MSG: begin
        write_d     = 1'b1;
        fsm_addr_d  = ADDR_MSG_FIRST + word_t'(msg_idx_d);
        // The buffer is loaded on the accept edge, so the first word comes
        // straight from the input port.
        writedata_d = accept ? blk_word(blk_data, 0) : msg_buf[msg_idx_d];
      end
      ST_WR_START: begin
        write_d     = 1'b1;
        fsm_addr_d  = ADDR_CTRL;
        writedata_d = CTRL_START;
      end
      ST_POLL: begin
        fsm_read_d = 1'b1;
        fsm_addr_d = ADDR_CTRL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      msg_idx   <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      write     <= 1'b0;
      fsm_read  <= 1'b0;
      fsm_addr  <= '0;
      writedata <= '0;
    end else begin
      state     <= state_d;
      msg_idx   <= msg_idx_d;
      poll_cnt  <= poll_cnt_d;
      gap_cnt   <= gap_cnt_d;
      write     <= write_d;
      fsm_read  <= fsm_read_d;
      fsm_addr  <= fsm_addr_d;
      writedata <= writedata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < MSG_WORDS; i++) msg_buf[i] <= blk_word(blk_data, i);
    end
  end

  sha1_host_rd_pipe u_rd_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (rd_start),
    .readdata     (readdata),
    .read         (pipe_read),
    .address      (pipe_addr),
    .last_capture (pipe_last),
    .digest       (digest)
  );

  // Both sources are registered and never active together.
  assign read         = fsm_read | pipe_read;
  assign address      = pipe_read ? pipe_addr : fsm_addr;
  assign blk_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign digest_valid = (state == ST_DONE);
  assign timeout_err  = (state == ST_ABORT);
  assign state_dbg    = state;

endmodule

// File: tb/tb_sha1_avalon_host.sv
module tb_sha1_avalon_host;
  import sha1_pkg::*;

  localparam int TO_POLLS = 8;
  localparam int GAP      = 3;
  localparam logic [511:0] ABC_BLK    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [159:0] ABC_DIGEST = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] FIX_DIGEST = 160'h11111111_22222222_33333333_44444444_55555555;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         blk_valid, blk_ready;
  logic [511:0] blk_data;
  logic [159:0] digest;
  logic         digest_valid, timeout_err, busy, write, read;
  logic [31:0]  address, writedata, readdata;
  logic [3:0]   state_dbg;

  sha1_avalon_host #(.TIMEOUT_POLLS(TO_POLLS), .POLL_GAP(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .digest       (digest),
    .digest_valid (digest_valid),
    .timeout_err  (timeout_err),
    .busy         (busy),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // slave model
  int          done_on_poll;
  bit          bfm_fixed;
  int          poll_seen = 0;
  logic [31:0] slv_msg [1:16];
  logic [159:0] abc_dig_v = ABC_DIGEST;

  function automatic logic [31:0] abc_word(input int i);
    if (i == 1) return 32'h61626380;
    if (i == 16) return 32'h00000018;
    return 32'h0;
  endfunction

  function automatic logic [31:0] bfm_dig(input int idx);
    bit ok = 1'b1;
    if (bfm_fixed) return 32'(32'h11111111 * (idx + 1));
    for (int i = 1; i <= 16; i++) if (slv_msg[i] !== abc_word(i)) ok = 1'b0;
    if (ok) return abc_dig_v[159 - 32*idx -: 32];
    return 32'(32'hBAD00000 + idx);
  endfunction

  always @(posedge clk) begin
    readdata <= 32'hFFFFFFFF;
    if (write) begin
      if (address == 0) begin
        if (writedata[0]) poll_seen <= 0;
      end else if (address <= 16) slv_msg[address[4:0]] <= writedata;
    end
    if (read) begin
      if (address == 0) begin
        readdata  <= (done_on_poll != 0 && poll_seen + 1 >= done_on_poll) ? 32'h2 : 32'h0;
        poll_seen <= poll_seen + 1;
      end else if (address >= 17 && address <= 21) begin
        readdata <= bfm_dig(int'(address) - 17);
      end
    end
  end

  // bus monitor
  int          cyc = 0;
  logic [63:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] rd_q[$];
  int          rd_cyc_q[$];
  int          acc_cyc_q[$];
  int          dv_cyc_q[$];
  int          n_dv = 0, n_to = 0, n_rdy_busy = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (write) begin wr_q.push_back({address, writedata}); wr_cyc_q.push_back(cyc); end
      if (read) begin rd_q.push_back(address); rd_cyc_q.push_back(cyc); end
      if (blk_valid && blk_ready) acc_cyc_q.push_back(cyc);
      if (digest_valid) begin n_dv++; dv_cyc_q.push_back(cyc); end
      if (timeout_err) n_to++;
      if (busy && blk_ready) n_rdy_busy++;
    end
    cyc++;
  end

  // scoreboard
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int base);
    int k = 0;
    chk({tag, "_count"}, wr_q.size() - base, exp_q.size());
    while (exp_q.size() > 0) begin
      logic [63:0] e = exp_q.pop_front();
      logic [63:0] o = 'x;
      if (base + k < wr_q.size()) o = wr_q[base + k];
      chk(tag, o, e);
      k++;
    end
  endtask

  task automatic check_reads(input string tag, input int base);
    int k = 0;
    chk({tag, "_count"}, rd_q.size() - base, exp_q.size());
    while (exp_q.size() > 0) begin
      logic [63:0] e = exp_q.pop_front();
      logic [63:0] o = 'x;
      if (base + k < rd_q.size()) o = {32'h0, rd_q[base + k]};
      chk(tag, o, e);
      k++;
    end
  endtask

  // driver tasks; every wait goes through tick so the protocol rules are
  // checked on every cycle
  task automatic tick();
    @(negedge clk);
    if (reset_n) begin
      chk("proto_wr_rd_overlap", write && read, 1'b0);
      chk("proto_x_strobe", $isunknown({write, read}), 1'b0);
      chk("proto_addr_range", (write || read) && (address > 21), 1'b0);
    end
  endtask

  task automatic offer(input logic [511:0] d);
    int n = acc_cyc_q.size();
    blk_data  = d;
    blk_valid = 1'b1;
    for (int i = 0; i < 50 && acc_cyc_q.size() == n; i++) tick();
    blk_valid = 1'b0;
    blk_data  = '1;
    chk("accept_seen", acc_cyc_q.size() - n, 1);
  endtask

  task automatic wait_end(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      seen = digest_valid || timeout_err;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, ab, db, dv0, to0, rdy0;
    bit found;
    blk_valid    = 1'b0;
    blk_data     = '0;
    reset_n      = 1'b0;
    done_on_poll = 2;
    bfm_fixed    = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_write", write, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_digest", digest, 160'h0);
    chk("rst_digest_valid", digest_valid, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_state", state_dbg, 4'(ST_IDLE));

    // 1: "abc" block, done on 2nd poll
    wb = wr_q.size(); rb = rd_q.size(); ab = acc_cyc_q.size(); db = dv_cyc_q.size();
    dv0 = n_dv; to0 = n_to; rdy0 = n_rdy_busy;
    offer(ABC_BLK);
    wait_end("t1_end");
    chk("t1_digest", digest, ABC_DIGEST);
    chk("t1_busy_at_dv", busy, 1'b1);
    tick();
    chk("t1_dv_pulse_end", digest_valid, 1'b0);
    for (int i = 1; i <= 16; i++) exp_q.push_back({32'(i), abc_word(i)});
    exp_q.push_back({ADDR_CTRL, CTRL_START});
    check_writes("t1_wr", wb);
    exp_q = '{64'd0, 64'd0, 64'd17, 64'd18, 64'd19, 64'd20, 64'd21};
    check_reads("t1_rd", rb);
    chk("t1_first_wr_lat", wr_cyc_q[wb] - acc_cyc_q[ab], 1);
    chk("t1_start_lat", wr_cyc_q[wb + 16] - acc_cyc_q[ab], 17);
    chk("t1_first_poll_lat", rd_cyc_q[rb] - acc_cyc_q[ab], 18);
    chk("t1_poll_spacing", rd_cyc_q[rb + 1] - rd_cyc_q[rb], GAP + 2);
    chk("t1_dig_burst", rd_cyc_q[rb + 6] - rd_cyc_q[rb + 2], 4);
    chk("t1_dv_lat", dv_cyc_q[db] - rd_cyc_q[rb + 1], 8);
    chk("t1_dv_count", n_dv - dv0, 1);
    chk("t1_to_count", n_to - to0, 0);
    chk("t1_ready_while_busy", n_rdy_busy - rdy0, 0);

    // 2: back-to-back blocks with blk_valid held high
    ab = acc_cyc_q.size(); db = dv_cyc_q.size(); dv0 = n_dv; rdy0 = n_rdy_busy;
    blk_data  = ABC_BLK;
    blk_valid = 1'b1;
    wait_end("t2_end1");
    chk("t2_digest1", digest, ABC_DIGEST);
    for (int i = 0; i < 5 && acc_cyc_q.size() < ab + 2; i++) tick();
    blk_valid = 1'b0;
    blk_data  = '1;
    chk("t2_accepts", acc_cyc_q.size() - ab, 2);
    chk("t2_b2b_accept", acc_cyc_q[ab + 1] - dv_cyc_q[db], 1);
    wait_end("t2_end2");
    chk("t2_digest2", digest, ABC_DIGEST);
    tick();
    chk("t2_dv_count", n_dv - dv0, 2);
    chk("t2_ready_while_busy", n_rdy_busy - rdy0, 0);

    // 3: slave never reports done
    done_on_poll = 0;
    rb = rd_q.size(); dv0 = n_dv; to0 = n_to;
    offer(ABC_BLK);
    wait_end("t3_end");
    chk("t3_timeout_err", timeout_err, 1'b1);
    chk("t3_no_dv", digest_valid, 1'b0);
    chk("t3_digest_kept", digest, ABC_DIGEST);
    tick();
    chk("t3_ready_after", blk_ready, 1'b1);
    chk("t3_busy_after", busy, 1'b0);
    chk("t3_to_pulse_end", timeout_err, 1'b0);
    for (int i = 0; i < TO_POLLS; i++) exp_q.push_back(64'd0);
    check_reads("t3_rd", rb);
    chk("t3_poll_span", rd_cyc_q[rb + TO_POLLS - 1] - rd_cyc_q[rb], (TO_POLLS - 1) * (GAP + 2));
    chk("t3_to_count", n_to - to0, 1);
    chk("t3_dv_count", n_dv - dv0, 0);

    // 4: done on 3rd poll, fixed digest words
    done_on_poll = 3;
    bfm_fixed    = 1'b1;
    rb = rd_q.size(); db = dv_cyc_q.size(); dv0 = n_dv;
    offer(ABC_BLK);
    wait_end("t4_end");
    chk("t4_digest", digest, FIX_DIGEST);
    tick();
    exp_q = '{64'd0, 64'd0, 64'd0, 64'd17, 64'd18, 64'd19, 64'd20, 64'd21};
    check_reads("t4_rd", rb);
    chk("t4_poll_spacing", rd_cyc_q[rb + 2] - rd_cyc_q[rb + 1], GAP + 2);
    chk("t4_dv_lat", dv_cyc_q[db] - rd_cyc_q[rb + 2], 8);
    chk("t4_dv_count", n_dv - dv0, 1);

    // 5: reset in the middle of the message writes
    bfm_fixed    = 1'b0;
    done_on_poll = 2;
    wb = wr_q.size();
    offer({16{32'hDEADBEEF}});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      for (int k = wb; k < wr_q.size(); k++) if (wr_q[k][63:32] == 32'd7) found = 1'b1;
    end
    chk("t5_addr7_seen", found, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_write", write, 1'b0);
    chk("t5_rst_read", read, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_digest", digest, 160'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wb = wr_q.size();
    offer(ABC_BLK);
    wait_end("t5_end");
    chk("t5_digest", digest, ABC_DIGEST);
    tick();
    for (int i = 1; i <= 16; i++) exp_q.push_back({32'(i), abc_word(i)});
    exp_q.push_back({ADDR_CTRL, CTRL_START});
    check_writes("t5_wr", wb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
